ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU control unit (fetch/operand
//  reads) and the program loader/debug port (reads and writes). One access per cycle,
//  round-robin on conflict, bounded loader bursts, fixed-latency read return tagged to
//  the winning requester. Sits between control_unit/PC/MAR and the RAM macro.
// PARAMETERS
//  ADDR_W     4   RAM address width
//  DATA_W     8   RAM data width
//  RD_LAT     1   RAM read latency in cycles (1..4)
//  MAX_BURST  4   max consecutive loader grants under ldr_lock while CPU waits (1..15)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high
//  cpu_req    in   1       CPU read request; held with cpu_addr until cpu_gnt
//  cpu_addr   in   ADDR_W  CPU read address
//  cpu_gnt    out  1       CPU access issued this cycle
//  cpu_wait   out  1       cpu_req & ~cpu_gnt; control unit freezes state while high
//  cpu_rvalid out  1       CPU read data valid
//  cpu_rdata  out  DATA_W  CPU read data
//  ldr_req    in   1       loader request; held with addr/we/wdata until ldr_gnt
//  ldr_we     in   1       1 = write, 0 = read
//  ldr_lock   in   1       loader requests back-to-back grants (burst)
//  ldr_addr   in   ADDR_W  loader address
//  ldr_wdata  in   DATA_W  loader write data
//  ldr_gnt    out  1       loader access issued this cycle
//  ldr_rvalid out  1       loader read data valid (reads only)
//  ldr_rdata  out  DATA_W  loader read data
//  ram_en     out  1       RAM access strobe
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid RD_LAT cycles after ram_en & ~ram_we
// BEHAVIOUR
//  - Grant decision combinational from req inputs + registered state; at most one gnt/cycle.
//  - ram_* driven combinationally from winner: CPU -> en=1,we=0,addr=cpu_addr;
//    loader -> en=1,we=ldr_we,addr=ldr_addr,wdata=ldr_wdata. No grant -> en=0,we=0,addr=0,wdata=0.
//  - Arbitration state: last_owner (CPU/LDR), burst_cnt (4b).
//    Only one requester -> it wins. Both request -> requester not equal last_owner wins,
//    except: last_owner=LDR & ldr_lock & burst_cnt<MAX_BURST -> loader wins again.
//  - burst_cnt: +1 on each loader grant while ldr_lock; cleared on any CPU grant or
//    when ldr_lock low. Saturates at MAX_BURST, forcing CPU grant next conflict cycle.
//  - last_owner updates on every grant; unchanged on idle cycles.
//  - Read return: RD_LAT-deep shift pipe of {valid, owner}; entry pushed on each read grant.
//    Pipe output valid -> owner's rvalid=1 for exactly one cycle, rdata=ram_rdata; other
//    requester's rvalid=0. Back-to-back reads return back-to-back, in issue order.
//  - rdata outputs = ram_rdata when own rvalid, else 0.
//  - Loader writes take effect at the grant edge; no rvalid. Read of same address on the
//    next grant returns the new data.
//  - Reset (any time): last_owner=LDR (CPU wins first conflict), burst_cnt=0, read pipe
//    cleared; all outputs 0 while reset high. In-flight reads are discarded, never returned.
//  - Requester dropping req before gnt: legal, request is withdrawn, no state change.
//  - X on inactive requester's addr/data must not propagate to ram_* outputs.
// TESTING
//  1 Reset, cpu_req=1 addr=4'h3, RAM[3]=8'hA5 -> cpu_gnt same cycle, cpu_rvalid with
//    cpu_rdata=8'hA5 exactly RD_LAT=1 cycle later; ldr_* outputs stay 0.
//  2 Both request from reset, no lock -> grants CPU,LDR,CPU,LDR alternate; cpu_wait high
//    only on LDR cycles.
//  3 ldr_lock=1, ldr writes 0..7 with data 8'h10+i, cpu_req held, MAX_BURST=4 ->
//    LDR x4, CPU x1, LDR x4...; RAM then reads back 8'h10..8'h17.
//  4 RD_LAT=3, interleaved CPU read addr 1 and loader read addr 2 back-to-back ->
//    rvalids arrive cycles +3,+4 on correct ports with correct data, never swapped.
//  5 Assert reset 1 cycle after CPU read grant (RD_LAT=2) -> no cpu_rvalid ever returned;
//    after release first conflict goes to CPU.
//  6 Loader write 8'h5C to addr F then CPU read addr F next cycle -> cpu_rdata=8'h5C.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between the CPU read port and the loader/debug port.
// One access per cycle, round-robin on conflict, bounded loader bursts, tagged fixed-latency read return.
module ram_port_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_wait,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic              ldr_lock,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    // Handshake: a requester holds req plus its address/data until it sees gnt in the
    // same cycle; gnt means the access is issued this cycle. Dropping req before gnt
    // withdraws the request without side effects.

    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_t            last_owner;
    logic [3:0]        burst_cnt;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;
    logic              win_cpu;
    logic              win_ldr;
    logic              rd_push;
    logic              ret_valid;
    logic              ret_ldr;

    always_comb begin
        win_cpu = 1'b0;
        win_ldr = 1'b0;
        if (!reset) begin
            if (cpu_req && ldr_req) begin
                // A locked loader keeps the port until its burst allowance runs out.
                if (last_owner == OWN_LDR && !(ldr_lock && burst_cnt < BURST_MAX))
                    win_cpu = 1'b1;
                else
                    win_ldr = 1'b1;
            end else begin
                win_cpu = cpu_req;
                win_ldr = ldr_req;
            end
        end
    end

    assign rd_push = win_cpu | (win_ldr & ~ldr_we);

    // Inactive requester inputs never reach the RAM, even if they are X.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (win_cpu) begin
            ram_en   = 1'b1;
            ram_addr = cpu_addr;
        end else if (win_ldr) begin
            ram_en    = 1'b1;
            ram_we    = ldr_we;
            ram_addr  = ldr_addr;
            ram_wdata = ldr_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWN_LDR;
            burst_cnt  <= 4'd0;
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            if (win_cpu)
                last_owner <= OWN_CPU;
            else if (win_ldr)
                last_owner <= OWN_LDR;

            if (win_cpu || !ldr_lock)
                burst_cnt <= 4'd0;
            else if (win_ldr && burst_cnt < BURST_MAX)
                burst_cnt <= burst_cnt + 4'd1;

            pipe_valid[0] <= rd_push;
            pipe_owner[0] <= win_ldr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    assign ret_valid = pipe_valid[RD_LAT-1] & ~reset;
    assign ret_ldr   = pipe_owner[RD_LAT-1];

    assign cpu_gnt    = win_cpu;
    assign ldr_gnt    = win_ldr;
    assign cpu_wait   = cpu_req & ~win_cpu & ~reset;
    assign cpu_rvalid = ret_valid & ~ret_ldr;
    assign ldr_rvalid = ret_valid & ret_ldr;
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign ldr_rdata  = ldr_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances with RD_LAT 1,2,3 share the stimulus and
// are compared against a cycle-level reference model of the arbitration rules.
module tb_ram_port_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       cpu_req = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic       ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
    logic [3:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;

    logic [2:0] cpu_gnt_a, cpu_wait_a, cpu_rvalid_a, ldr_gnt_a, ldr_rvalid_a, ram_en_a, ram_we_a;
    logic [7:0] cpu_rdata_a [3];
    logic [7:0] ldr_rdata_a [3];
    logic [3:0] ram_addr_a [3];
    logic [7:0] ram_wdata_a [3];
    logic [7:0] ram_rdata_a [3];
    logic [7:0] ram_mem [16];

    for (genvar g = 0; g < 3; g++) begin : lat
        logic [7:0] rdp [g+1];
        ram_port_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(g+1), .MAX_BURST(MAXB)) u_dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt_a[g]), .cpu_wait(cpu_wait_a[g]),
            .cpu_rvalid(cpu_rvalid_a[g]), .cpu_rdata(cpu_rdata_a[g]),
            .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
            .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt_a[g]), .ldr_rvalid(ldr_rvalid_a[g]),
            .ldr_rdata(ldr_rdata_a[g]), .ram_en(ram_en_a[g]), .ram_we(ram_we_a[g]),
            .ram_addr(ram_addr_a[g]), .ram_wdata(ram_wdata_a[g]), .ram_rdata(ram_rdata_a[g])
        );
        // RAM read path: data captured at the issue edge, then delayed; junk when not reading.
        always @(posedge clk) begin
            rdp[0] <= (ram_en_a[g] && !ram_we_a[g]) ? ram_mem[ram_addr_a[g]] : 8'($urandom);
            for (int i = 1; i <= g; i++) rdp[i] <= rdp[i-1];
        end
        assign ram_rdata_a[g] = rdp[g];
    end

    always @(posedge clk)
        if (ram_en_a[0] && ram_we_a[0]) ram_mem[ram_addr_a[0]] <= ram_wdata_a[0];

    // ---------------- reference model ----------------
    typedef struct {int due; bit owner; logic [7:0] data;} ret_t;
    ret_t       rq [3][$];
    logic [7:0] m_mem [16];
    bit         m_last;
    int         m_burst;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    function automatic int exp_win();
        if (reset) return 0;
        if (cpu_req && ldr_req) begin
            if (m_last && ldr_lock && m_burst < MAXB) return 2;
            return m_last ? 1 : 2;
        end
        if (cpu_req) return 1;
        if (ldr_req) return 2;
        return 0;
    endfunction

    function automatic logic [16:0] exp_bus(int w);
        logic [16:0] b;
        b = '0;
        if (w == 1) b = {3'b100, 2'b10, cpu_addr, 8'h00};
        else if (w == 2) b = {3'b010, 1'b1, ldr_we, ldr_addr, ldr_wdata};
        b[14] = cpu_req && w != 1 && !reset;
        return b;
    endfunction

    function automatic logic [16:0] got_bus(int k);
        return {cpu_gnt_a[k], ldr_gnt_a[k], cpu_wait_a[k], ram_en_a[k], ram_we_a[k],
                ram_addr_a[k], ram_wdata_a[k]};
    endfunction

    function automatic logic [53:0] exp_rets();
        logic [53:0] r;
        r = '0;
        for (int li = 0; li < 3; li++)
            if (rq[li].size() > 0 && rq[li][0].due == cyc)
                r[li*18 +: 18] = rq[li][0].owner ? {2'b01, 8'h00, rq[li][0].data}
                                                 : {2'b10, rq[li][0].data, 8'h00};
        return r;
    endfunction

    function automatic logic [53:0] got_rets();
        logic [53:0] r;
        for (int k = 0; k < 3; k++)
            r[k*18 +: 18] = {cpu_rvalid_a[k], ldr_rvalid_a[k], cpu_rdata_a[k], ldr_rdata_a[k]};
        return r;
    endfunction

    task automatic model_init();
        m_last = 1'b1;
        m_burst = 0;
        cyc = 0;
        for (int li = 0; li < 3; li++) rq[li].delete();
    endtask

    // Clock edge: apply the winner's effect to the model, then step past the edge.
    task automatic advance(input int w);
        @(posedge clk);
        for (int li = 0; li < 3; li++)
            while (rq[li].size() > 0 && rq[li][0].due <= cyc) void'(rq[li].pop_front());
        if (w == 1) begin
            for (int li = 0; li < 3; li++) rq[li].push_back('{due: cyc+li+1, owner: 1'b0, data: m_mem[cpu_addr]});
            m_last = 1'b0;
            m_burst = 0;
        end else if (w == 2) begin
            if (ldr_we) m_mem[ldr_addr] = ldr_wdata;
            else for (int li = 0; li < 3; li++)
                rq[li].push_back('{due: cyc+li+1, owner: 1'b1, data: m_mem[ldr_addr]});
            m_last = 1'b1;
            m_burst = ldr_lock ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
        end else if (!ldr_lock) begin
            m_burst = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_addr = 'x;
        ldr_req = 1'b0; ldr_we = 'x; ldr_addr = 'x; ldr_wdata = 'x; ldr_lock = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        model_init();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        cpu_req = 1'b1; cpu_addr = 4'h7; ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b1;
        ldr_addr = 4'h2; ldr_wdata = 8'h99;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_bus(k) !== 17'h0 || got_rets() !== 54'h0) begin
                errors++; $display("FAIL reset_outputs inst %0d got %h/%h want 0", k, got_bus(k), got_rets());
            end
        end
        do_reset();
    endtask

    task automatic test_preload();
        int w;
        for (int i = 0; i < 16; i++) begin
            ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'(i);
            ldr_wdata = (i == 3) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            w = exp_win();
            checks++;
            if (got_bus(0) !== exp_bus(w)) begin
                errors++; $display("FAIL preload_bus got %h want %h", got_bus(0), exp_bus(w));
            end
            advance(w);
        end
        drive_idle();
    endtask

    task automatic test_single_read();
        int w;
        do_reset();
        cpu_req = 1'b1; cpu_addr = 4'h3;
        @(negedge clk);
        w = exp_win();
        checks++;
        if (cpu_gnt_a[0] !== 1'b1 || ram_addr_a[0] !== 4'h3) begin
            errors++; $display("FAIL single_gnt got %b addr %h want 1 addr 3", cpu_gnt_a[0], ram_addr_a[0]);
        end
        advance(w);
        drive_idle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid_a[0] !== 1'b1 || cpu_rdata_a[0] !== 8'hA5 || ldr_rvalid_a[0] !== 1'b0 || ldr_rdata_a[0] !== 8'h00) begin
            errors++; $display("FAIL single_ret got v%b d%h ldr v%b d%h want v1 dA5 ldr 0",
                               cpu_rvalid_a[0], cpu_rdata_a[0], ldr_rvalid_a[0], ldr_rdata_a[0]);
        end
        checks++;
        if (got_rets() !== exp_rets()) begin
            errors++; $display("FAIL single_rets got %h want %h", got_rets(), exp_rets());
        end
        advance(exp_win());
    endtask

    task automatic test_alternate();
        int w;
        do_reset();
        cpu_req = 1'b1; cpu_addr = 4'h5; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h9; ldr_wdata = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w = exp_win();
            checks++;
            if (cpu_gnt_a[0] !== (i % 2 == 0) || ldr_gnt_a[0] !== (i % 2 == 1) || cpu_wait_a[0] !== (i % 2 == 1)) begin
                errors++; $display("FAIL alternate cycle %0d got gnt %b%b wait %b", i, cpu_gnt_a[0], ldr_gnt_a[0], cpu_wait_a[0]);
            end
            checks++;
            if (got_bus(0) !== exp_bus(w) || got_rets() !== exp_rets()) begin
                errors++; $display("FAIL alternate_model got %h/%h want %h/%h", got_bus(0), got_rets(), exp_bus(w), exp_rets());
            end
            advance(w);
        end
        drive_idle();
    endtask

    task automatic test_burst();
        int w, wi, run, max_run, n;
        logic [7:0] e;
        do_reset();
        wi = 0; run = 0; max_run = 0; n = 0;
        cpu_req = 1'b1; cpu_addr = 4'hC; ldr_lock = 1'b1;
        while (wi < 8 && n < 40) begin
            ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'(wi); ldr_wdata = 8'h10 + 8'(wi);
            @(negedge clk);
            w = exp_win();
            checks++;
            if (got_bus(0) !== exp_bus(w) || got_rets() !== exp_rets()) begin
                errors++; $display("FAIL burst_model got %h/%h want %h/%h", got_bus(0), got_rets(), exp_bus(w), exp_rets());
            end
            run = (w == 2) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (w == 2) wi++;
            advance(w);
            n++;
        end
        checks++;
        if (wi != 8 || max_run != MAXB) begin
            errors++; $display("FAIL burst_runs got writes %0d run %0d want 8 run %0d", wi, max_run, MAXB);
        end
        drive_idle();
        for (int i = 0; i <= 8; i++) begin
            cpu_req = (i < 8); cpu_addr = (i < 8) ? 4'(i) : 'x;
            @(negedge clk);
            e = 8'h10 + 8'(i - 1);
            if (i > 0) begin
                checks++;
                if (cpu_rvalid_a[0] !== 1'b1 || cpu_rdata_a[0] !== e) begin
                    errors++; $display("FAIL burst_readback addr %0d got v%b %h want %h", i-1, cpu_rvalid_a[0], cpu_rdata_a[0], e);
                end
            end
            advance(exp_win());
        end
        drive_idle();
    endtask

    task automatic test_interleave();
        int w, gc, gl;
        gc = -10; gl = -10;
        cpu_req = 1'b1; cpu_addr = 4'h1; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h2; ldr_wdata = 8'h00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            w = exp_win();
            checks++;
            if (got_bus(0) !== exp_bus(w) || got_rets() !== exp_rets()) begin
                errors++; $display("FAIL interleave_model got %h/%h want %h/%h", got_bus(0), got_rets(), exp_bus(w), exp_rets());
            end
            if (i == gc + 3) begin
                checks++;
                if (cpu_rvalid_a[2] !== 1'b1 || cpu_rdata_a[2] !== m_mem[1] || ldr_rvalid_a[2] !== 1'b0) begin
                    errors++; $display("FAIL interleave_cpu got v%b %h want %h", cpu_rvalid_a[2], cpu_rdata_a[2], m_mem[1]);
                end
            end
            if (i == gl + 3) begin
                checks++;
                if (ldr_rvalid_a[2] !== 1'b1 || ldr_rdata_a[2] !== m_mem[2] || cpu_rvalid_a[2] !== 1'b0) begin
                    errors++; $display("FAIL interleave_ldr got v%b %h want %h", ldr_rvalid_a[2], ldr_rdata_a[2], m_mem[2]);
                end
            end
            advance(w);
            if (w == 1) begin gc = i; cpu_req = 1'b0; cpu_addr = 'x; end
            if (w == 2) begin gl = i; ldr_req = 1'b0; ldr_addr = 'x; ldr_we = 'x; ldr_wdata = 'x; end
        end
        checks++;
        if (gc < 0 || gl < 0 || (gc - gl != 1 && gl - gc != 1)) begin
            errors++; $display("FAIL interleave_grants got cpu@%0d ldr@%0d want adjacent", gc, gl);
        end
    endtask

    task automatic test_reset_inflight();
        int w;
        cpu_req = 1'b1; cpu_addr = 4'h6;
        @(negedge clk);
        w = exp_win();
        checks++;
        if (cpu_gnt_a[1] !== 1'b1) begin
            errors++; $display("FAIL inflight_gnt got %b want 1", cpu_gnt_a[1]);
        end
        advance(w);
        reset = 1'b1;
        model_init();
        #1;
        checks++;
        if (got_bus(1) !== 17'h0 || got_rets() !== 54'h0) begin
            errors++; $display("FAIL inflight_reset got %h/%h want 0", got_bus(1), got_rets());
        end
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_rvalid_a[1] !== 1'b0 || got_rets() !== exp_rets()) begin
                errors++; $display("FAIL inflight_discard got v%b rets %h want 0", cpu_rvalid_a[1], got_rets());
            end
            advance(exp_win());
        end
        cpu_req = 1'b1; cpu_addr = 4'h0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h4; ldr_wdata = 8'h00;
        @(negedge clk);
        w = exp_win();
        checks++;
        if (cpu_gnt_a[1] !== 1'b1 || ldr_gnt_a[1] !== 1'b0) begin
            errors++; $display("FAIL inflight_first got gnt %b%b want 10", cpu_gnt_a[1], ldr_gnt_a[1]);
        end
        advance(w);
        drive_idle();
    endtask

    task automatic test_write_read();
        int w;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h5C;
        @(negedge clk);
        w = exp_win();
        advance(w);
        drive_idle();
        cpu_req = 1'b1; cpu_addr = 4'hF;
        @(negedge clk);
        w = exp_win();
        advance(w);
        cpu_req = 1'b0; cpu_addr = 'x;
        @(negedge clk);
        checks++;
        if (cpu_rvalid_a[0] !== 1'b1 || cpu_rdata_a[0] !== 8'h5C) begin
            errors++; $display("FAIL write_read got v%b %h want 5C", cpu_rvalid_a[0], cpu_rdata_a[0]);
        end
        advance(exp_win());
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 400; i++) begin
            if (cpu_req && $urandom_range(0, 15) == 0) begin cpu_req = 1'b0; cpu_addr = 'x; end
            else if (!cpu_req && $urandom_range(0, 2) != 0) begin cpu_req = 1'b1; cpu_addr = 4'($urandom); end
            if (ldr_req && $urandom_range(0, 15) == 0) begin
                ldr_req = 1'b0; ldr_we = 'x; ldr_addr = 'x; ldr_wdata = 'x;
            end else if (!ldr_req && $urandom_range(0, 2) != 0) begin
                ldr_req = 1'b1; ldr_we = 1'($urandom); ldr_addr = 4'($urandom); ldr_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) ldr_lock = ~ldr_lock;
            @(negedge clk);
            w = exp_win();
            checks++;
            if (got_bus(0) !== exp_bus(w) || got_bus(2) !== exp_bus(w)) begin
                errors++; $display("FAIL random_bus cycle %0d got %h want %h", i, got_bus(0), exp_bus(w));
            end
            checks++;
            if (got_rets() !== exp_rets()) begin
                errors++; $display("FAIL random_rets cycle %0d got %h want %h", i, got_rets(), exp_rets());
            end
            advance(w);
            if (w == 1) begin cpu_req = 1'b0; cpu_addr = 'x; end
            if (w == 2) begin ldr_req = 1'b0; ldr_we = 'x; ldr_addr = 'x; ldr_wdata = 'x; end
        end
        drive_idle();
    endtask

    initial begin
        model_init();
        test_reset();
        test_preload();
        test_single_read();
        test_alternate();
        test_burst();
        test_interleave();
        test_reset_inflight();
        test_write_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
